mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, fixed-latency memory between the pipeline's instruction-fetch (IF) port and data (MEM-stage) port. Each cycle it grants at most one access, stalls the losing requester, and routes returning read data to the correct port via an in-flight tag pipeline. Data accesses win by default, and a starvation counter forces a fetch grant after a bounded number of losses. It sits between the IF/MEM stages and the unified memory, replacing separate instruction ROM and data RAM ports.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal ≥1
- STARVE_MAX, 4, consecutive fetch losses before a fetch grant is forced; legal ≥1

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held stable while if_stall=1
- if_addr  in  ADDR_W  fetch address
- if_flush  in  1  branch/jump redirect; kills in-flight fetch returns
- if_stall  out  1  fetch request not granted this cycle
- if_valid  out  1  fetch data returning this cycle
- if_rdata  out  DATA_W  fetch data, meaningful when if_valid=1
- d_req  in  1  data request; held stable while d_stall=1
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_stall  out  1  data request not granted this cycle
- d_valid  out  1  data read returning this cycle
- d_rdata  out  DATA_W  read data, meaningful when d_valid=1
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after mem_en

## Operation
- Per-cycle grant (combinational): eff_if = if_req & ~if_flush & ~reset; eff_d = d_req & ~reset.
  - Only one effective request: grant it.
  - Both: grant fetch if starve_cnt == STARVE_MAX; otherwise grant data.
- mem_en = any grant. mem_we = d_we only on a data grant, else 0. mem_addr/mem_wdata come from the granted port; mem_wdata = 0 on a fetch grant.
- if_stall = if_req & ~fetch_grant; d_stall = d_req & ~data_grant. During reset, stall = req.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - cleared on fetch grant, or when if_req=0;
  - incremented when both effective and data granted; saturates at STARVE_MAX.
- Tag pipeline, MEM_LAT deep; each entry is NONE, IF or D:
  - entry 0 loads IF on a fetch grant, D on a data read grant, and NONE otherwise (data writes produce no response).
  - When if_flush=1, every IF entry currently in flight is rewritten to NONE in the same edge.
- Return: the tail tag selects the port. if_valid = (tail==IF), d_valid = (tail==D). Both rdata outputs are driven from mem_rdata unconditionally.
- Reset: tag pipeline all NONE, starve_cnt=0. Outputs during and after the reset cycle: if_valid=d_valid=0, mem_en=0, mem_we=0.
- Reset mid-operation: all in-flight accesses are dropped and no valid is produced for them.

## Timing
- Grant, stall and mem_* are combinational in the request cycle, with zero added latency.
- A read granted in cycle t returns with valid in cycle t+MEM_LAT.
- One access per cycle. Back-to-back grants are sustained, and responses stay in order per port.
- A flush in cycle t suppresses any fetch grant in cycle t and all fetch returns due in cycles t+1..t+MEM_LAT−1+1. A return due in cycle t itself is still delivered; the consumer discards it.
- Worst-case fetch wait under continuous data traffic: STARVE_MAX stall cycles, then a grant.

## Structure
- Shared package: tag type (TAG_NONE, TAG_IF, TAG_D) and default parameter constants.
- One sub-module, arb_tag_pipe: MEM_LAT-deep tag shift register with per-entry IF kill on flush and synchronous clear.
- Grant logic and starve_cnt live in the top.

## Test plan
- Fetch only, if_addr=0x00,0x04,0x08 in consecutive cycles, MEM_LAT=1 → mem_en=1 each cycle, if_stall=0, if_valid=1 in the following cycles with the matching mem_rdata.
- d_req read and if_req together for 1 cycle → data granted, if_stall=1; the fetch is granted the next cycle; d_valid precedes if_valid by 1 cycle.
- Continuous d_req with if_req held, STARVE_MAX=4 → 4 data grants, then a fetch grant in cycle 5, then data again; starve_cnt returns to 0.
- MEM_LAT=3, fetch granted at cycles 0 and 1, if_flush at cycle 2 → no if_valid at cycles 3 or 4; data reads are unaffected.
- Data write d_we=1, addr=0x10, wdata=0xDEADBEEF → mem_we=1 with that address and data in the grant cycle; d_valid never asserts.
- reset asserted while 2 reads are in flight (MEM_LAT=3) → no valid output afterwards; mem_en=0 during reset; starve_cnt=0 afterwards.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: response tag type and default parameters shared by the arbiter slice
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_MEM_LAT = 1;
  localparam int DEF_STARVE_MAX = 4;
  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_D} tag_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, data port and unified memory bus around the arbiter
interface mem_port_arbiter_if import mem_port_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_stall;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_stall, if_valid, if_rdata, d_stall, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_tag_pipe.sv
// arb_tag_pipe: in-flight response tags; a flush kills every fetch tag still travelling
module arb_tag_pipe import mem_port_arbiter_pkg::*; #(
  parameter int DEPTH = DEF_MEM_LAT
) (
  input  logic clk,
  input  logic clr,
  input  logic flush,
  input  tag_e in_tag,
  output tag_e tail
);
  tag_e pipe [DEPTH];
  tag_e nxt [DEPTH];
  always_comb begin
    nxt[0] = in_tag;
    for (int i = 1; i < DEPTH; i++) nxt[i] = (flush && pipe[i-1] == TAG_IF) ? TAG_NONE : pipe[i-1];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++) pipe[i] <= clr ? TAG_NONE : nxt[i];
  assign tail = pipe[DEPTH-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-access-per-cycle fetch/data arbiter with starvation guard and tagged returns
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;
  logic eff_if, eff_d, starved, fetch_grant, data_grant;
  tag_e in_tag, tail;
  always_comb begin
    eff_if = bus.if_req & ~bus.if_flush & ~reset;
    eff_d = bus.d_req & ~reset;
    starved = starve_cnt == SW'(STARVE_MAX);
    fetch_grant = eff_if & (~eff_d | starved);
    data_grant = eff_d & ~fetch_grant;
    in_tag = fetch_grant ? TAG_IF : (data_grant & ~bus.d_we) ? TAG_D : TAG_NONE;
  end
  // a flushed fetch neither clears nor advances the count: it is simply not competing
  always_ff @(posedge clk)
    if (reset || fetch_grant || !bus.if_req) starve_cnt <= '0;
    else if (eff_if && data_grant && !starved) starve_cnt <= starve_cnt + SW'(1);
  arb_tag_pipe #(.DEPTH(MEM_LAT)) u_tags (
    .clk(clk),
    .clr(reset),
    .flush(bus.if_flush),
    .in_tag(in_tag),
    .tail(tail)
  );
  assign bus.mem_en = fetch_grant | data_grant;
  assign bus.mem_we = data_grant & bus.d_we;
  assign bus.mem_addr = fetch_grant ? bus.if_addr : bus.d_addr;
  assign bus.mem_wdata = data_grant ? bus.d_wdata : '0;
  assign bus.if_stall = bus.if_req & ~fetch_grant;
  assign bus.d_stall = bus.d_req & ~data_grant;
  assign bus.if_valid = (tail == TAG_IF) & ~reset;
  assign bus.d_valid = (tail == TAG_D) & ~reset;
  assign bus.if_rdata = bus.mem_rdata;
  assign bus.d_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of two arbiters (MEM_LAT 1 and 3) against an address-echo memory
module tb_mem_port_arbiter;
  localparam logic [31:0] MK = 32'hCAFE0000;
  logic clk = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  mem_port_arbiter_if b1();
  mem_port_arbiter_if b3();
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));
  logic [31:0] d1;
  logic [31:0] d3 [3];
  always @(posedge clk) begin
    d1 <= b1.mem_addr;
    d3[0] <= b3.mem_addr;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign b1.mem_rdata = d1 ^ MK;
  assign b3.mem_rdata = d3[2] ^ MK;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    b1.if_req = 0; b1.if_addr = 0; b1.if_flush = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b3.if_req = 0; b3.if_addr = 0; b3.if_flush = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
  endtask

  task automatic test_reset();
    tick();
    b1.if_req = 1; b1.d_req = 1; b3.if_req = 1; b3.d_req = 1;
    @(negedge clk);
    total++; if (b1.mem_en !== 1'b0) $display("FAIL rst_mem_en got %b exp 0", b1.mem_en); else passed++;
    total++; if (b1.if_stall !== 1'b1) $display("FAIL rst_if_stall got %b exp 1", b1.if_stall); else passed++;
    total++; if (b1.d_stall !== 1'b1) $display("FAIL rst_d_stall got %b exp 1", b1.d_stall); else passed++;
    total++; if ({b1.if_valid, b1.d_valid} !== 2'b00) $display("FAIL rst_valid got %b exp 00", {b1.if_valid, b1.d_valid}); else passed++;
    total++; if (b3.mem_en !== 1'b0) $display("FAIL rst_mem_en3 got %b exp 0", b3.mem_en); else passed++;
    tick();
    reset = 0; clr_in();
    @(negedge clk);
    total++; if ({b1.if_valid, b1.d_valid, b1.mem_we} !== 3'b000) $display("FAIL post_rst got %b exp 000", {b1.if_valid, b1.d_valid, b1.mem_we}); else passed++;
  endtask

  task automatic test_fetch_only();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    for (int c = 0; c < 5; c++) begin
      tick();
      b1.if_req = c < 3;
      b1.if_addr = c < 3 ? addrs[c] : 32'h0;
      @(negedge clk);
      if (c < 3) begin
        total++; if (b1.mem_en !== 1'b1 || b1.if_stall !== 1'b0) $display("FAIL fo_grant c%0d en %b stall %b exp 1 0", c, b1.mem_en, b1.if_stall); else passed++;
        total++; if (b1.mem_addr !== addrs[c]) $display("FAIL fo_addr c%0d got %h exp %h", c, b1.mem_addr, addrs[c]); else passed++;
      end
      if (c == 0 || c == 4) begin
        total++; if (b1.if_valid !== 1'b0) $display("FAIL fo_novalid c%0d got %b exp 0", c, b1.if_valid); else passed++;
      end else begin
        total++; if (b1.if_valid !== 1'b1) $display("FAIL fo_valid c%0d got %b exp 1", c, b1.if_valid); else passed++;
        total++; if (b1.if_rdata !== (addrs[c-1] ^ MK)) $display("FAIL fo_rdata c%0d got %h exp %h", c, b1.if_rdata, addrs[c-1] ^ MK); else passed++;
      end
    end
  endtask

  task automatic test_conflict();
    tick();
    b1.if_req = 1; b1.if_addr = 32'h40; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h100;
    @(negedge clk);
    total++; if ({b1.if_stall, b1.d_stall} !== 2'b10) $display("FAIL cf_stall0 got %b exp 10", {b1.if_stall, b1.d_stall}); else passed++;
    total++; if (b1.mem_addr !== 32'h100 || b1.mem_we !== 1'b0) $display("FAIL cf_mem0 got %h/%b exp 00000100/0", b1.mem_addr, b1.mem_we); else passed++;
    tick();
    b1.d_req = 0;
    @(negedge clk);
    total++; if (b1.if_stall !== 1'b0 || b1.mem_addr !== 32'h40) $display("FAIL cf_fetch1 got %b/%h exp 0/00000040", b1.if_stall, b1.mem_addr); else passed++;
    total++; if ({b1.d_valid, b1.if_valid} !== 2'b10) $display("FAIL cf_valid1 got %b exp 10", {b1.d_valid, b1.if_valid}); else passed++;
    total++; if (b1.d_rdata !== (32'h100 ^ MK)) $display("FAIL cf_drdata got %h exp %h", b1.d_rdata, 32'h100 ^ MK); else passed++;
    tick();
    b1.if_req = 0;
    @(negedge clk);
    total++; if ({b1.d_valid, b1.if_valid} !== 2'b01) $display("FAIL cf_valid2 got %b exp 01", {b1.d_valid, b1.if_valid}); else passed++;
    total++; if (b1.if_rdata !== (32'h40 ^ MK)) $display("FAIL cf_ifrdata got %h exp %h", b1.if_rdata, 32'h40 ^ MK); else passed++;
  endtask

  task automatic test_starve();
    for (int c = 0; c < 10; c++) begin
      tick();
      b1.if_req = 1; b1.if_addr = 32'h80; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h180;
      @(negedge clk);
      if (c == 4 || c == 9) begin
        total++; if ({b1.if_stall, b1.d_stall} !== 2'b01) $display("FAIL sv_force c%0d got %b exp 01", c, {b1.if_stall, b1.d_stall}); else passed++;
        total++; if (b1.mem_addr !== 32'h80) $display("FAIL sv_addr c%0d got %h exp 00000080", c, b1.mem_addr); else passed++;
      end else begin
        total++; if ({b1.if_stall, b1.d_stall} !== 2'b10) $display("FAIL sv_data c%0d got %b exp 10", c, {b1.if_stall, b1.d_stall}); else passed++;
      end
      if (c == 5) begin
        total++; if (dut1.starve_cnt !== 3'd0) $display("FAIL sv_cnt got %0d exp 0", dut1.starve_cnt); else passed++;
      end
    end
    tick();
    clr_in();
    tick();
  endtask

  task automatic test_write();
    tick();
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h10; b1.d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    total++; if ({b1.mem_en, b1.mem_we, b1.d_stall} !== 3'b110) $display("FAIL wr_ctl got %b exp 110", {b1.mem_en, b1.mem_we, b1.d_stall}); else passed++;
    total++; if (b1.mem_addr !== 32'h10) $display("FAIL wr_addr got %h exp 00000010", b1.mem_addr); else passed++;
    total++; if (b1.mem_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata got %h exp deadbeef", b1.mem_wdata); else passed++;
    for (int c = 1; c < 3; c++) begin
      tick();
      clr_in();
      @(negedge clk);
      total++; if (b1.d_valid !== 1'b0) $display("FAIL wr_novalid c%0d got %b exp 0", c, b1.d_valid); else passed++;
    end
  endtask

  task automatic test_flush();
    tick(); b3.if_req = 1; b3.if_addr = 32'h200;
    @(negedge clk);
    total++; if (b3.mem_en !== 1'b1 || b3.if_stall !== 1'b0) $display("FAIL fl_g0 got %b/%b exp 1/0", b3.mem_en, b3.if_stall); else passed++;
    tick(); b3.if_addr = 32'h204;
    tick(); b3.if_addr = 32'h300; b3.if_flush = 1; b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h400;
    @(negedge clk);
    total++; if ({b3.if_stall, b3.d_stall} !== 2'b10) $display("FAIL fl_stall got %b exp 10", {b3.if_stall, b3.d_stall}); else passed++;
    total++; if (b3.mem_addr !== 32'h400) $display("FAIL fl_addr got %h exp 00000400", b3.mem_addr); else passed++;
    for (int c = 3; c < 6; c++) begin
      tick(); clr_in();
      @(negedge clk);
      total++; if (b3.if_valid !== 1'b0) $display("FAIL fl_killed c%0d got %b exp 0", c, b3.if_valid); else passed++;
      total++; if (b3.d_valid !== (c == 5)) $display("FAIL fl_dvalid c%0d got %b exp %b", c, b3.d_valid, c == 5); else passed++;
    end
    total++; if (b3.d_rdata !== (32'h400 ^ MK)) $display("FAIL fl_drdata got %h exp %h", b3.d_rdata, 32'h400 ^ MK); else passed++;
    tick(); b3.if_req = 1; b3.if_addr = 32'h500;
    tick(); clr_in();
    tick();
    tick(); b3.if_req = 1; b3.if_addr = 32'h600; b3.if_flush = 1;
    @(negedge clk);
    total++; if ({b3.if_valid, b3.if_stall, b3.mem_en} !== 3'b110) $display("FAIL fl_due_now got %b exp 110", {b3.if_valid, b3.if_stall, b3.mem_en}); else passed++;
    total++; if (b3.if_rdata !== (32'h500 ^ MK)) $display("FAIL fl_due_rdata got %h exp %h", b3.if_rdata, 32'h500 ^ MK); else passed++;
    tick(); clr_in();
    tick();
  endtask

  task automatic test_reset_midflight();
    tick(); b3.if_req = 1; b3.if_addr = 32'h600;
    tick(); b3.if_addr = 32'h604; b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h700;
    @(negedge clk);
    total++; if ({b3.if_stall, b3.d_stall} !== 2'b10) $display("FAIL rm_pre got %b exp 10", {b3.if_stall, b3.d_stall}); else passed++;
    tick(); reset = 1;
    @(negedge clk);
    total++; if ({b3.mem_en, b3.mem_we, b3.if_stall, b3.d_stall} !== 4'b0011) $display("FAIL rm_during got %b exp 0011", {b3.mem_en, b3.mem_we, b3.if_stall, b3.d_stall}); else passed++;
    for (int c = 3; c < 6; c++) begin
      tick(); reset = 0; clr_in();
      @(negedge clk);
      total++; if ({b3.if_valid, b3.d_valid} !== 2'b00) $display("FAIL rm_valid c%0d got %b exp 00", c, {b3.if_valid, b3.d_valid}); else passed++;
      if (c == 3) begin
        total++; if (dut3.starve_cnt !== 3'd0) $display("FAIL rm_cnt got %0d exp 0", dut3.starve_cnt); else passed++;
      end
    end
  endtask

  initial begin
    reset = 1;
    clr_in();
    test_reset();
    test_fetch_only();
    test_conflict();
    test_starve();
    test_write();
    test_flush();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
